// File: rtl/seq_pattern_tx.sv
// Serial stimulus transmitter: FIFO-buffered parallel words shifted out MSB-first,
// with a tracker that produces the expected detector pulse and a match count.
module seq_pattern_tx #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             exp_op,
    output logic [15:0]      match_cnt,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = PLEN - 1;
    localparam int FW = $clog2(PLEN + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sh;
    logic [HW-1:0]    hist;
    logic [FW-1:0]    fill;
    logic             push;
    logic             pop;
    logic             last_bit;
    logic             match;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign last_bit = (idx == IW'(WIDTH - 1));
    assign pop      = (count != '0) && ((state == IDLE) || last_bit);
    assign match    = ser_valid && (fill >= FW'(PLEN - 1)) && ({hist, ser_out} == PATTERN);
    assign busy     = (count != '0) || (state == SHIFT);

    // FIFO: storage is never reset, only the pointers and occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Shifter: sh holds the bits still to follow the one on ser_out
    always_ff @(posedge clk) begin
        if (pop) begin
            sh <= mem[rd_ptr] << 1;
        end else begin
            sh <= sh << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
        end else if (pop) begin
            state     <= SHIFT;
            idx       <= '0;
            ser_out   <= mem[rd_ptr][WIDTH-1];
            ser_valid <= 1'b1;
        end else if (state == SHIFT && !last_bit) begin
            idx     <= idx + IW'(1);
            ser_out <= sh[WIDTH-1];
        end else begin
            state     <= IDLE;
            idx       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
        end
    end

    // Tracker: any invalid cycle breaks the stream, so history restarts empty
    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '0;
            fill      <= '0;
            exp_op    <= 1'b0;
            match_cnt <= '0;
        end else begin
            exp_op <= match;
            if (match) begin
                match_cnt <= sat_inc16(match_cnt);
            end
            if (ser_valid) begin
                hist <= HW'({hist, ser_out});
                if (fill < FW'(PLEN - 1)) begin
                    fill <= fill + FW'(1);
                end
            end else begin
                hist <= '0;
                fill <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and random bench for seq_pattern_tx: word scoreboard, overlapping 1011
// stream detector model, and hand-computed timing expectations.
module tb_seq_pattern_tx;

    localparam logic [3:0] PAT = 4'b1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        ser_out;
    logic        ser_valid;
    logic        exp_op;
    logic [15:0] match_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_pattern_tx #(.WIDTH(8), .DEPTH(4), .PLEN(4), .PATTERN(PAT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .exp_op(exp_op), .match_cnt(match_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: accepted words in order, plus the detector seen on the bit stream
    logic [7:0] q[$];
    logic [7:0] part;
    int         pbits = 0;
    int         run = 0;
    logic [3:0] last4 = 4'h0;
    logic       pending = 1'b0;
    int         mcnt = 0;
    logic       prev_exp = 1'b0;
    int         exp_pulses = 0;
    bit         started = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("exp_op", exp_op, pending);
            chk("match_cnt", match_cnt, mcnt);
            chk("exp_op_consecutive", 32'(prev_exp & exp_op), 0);
            if (ser_valid) begin
                chk("busy_while_shifting", busy, 1);
                part = {part[6:0], ser_out};
                pbits++;
                if (pbits == 8) begin
                    chk("word_expected", 32'(q.size() != 0), 1);
                    if (q.size() != 0) chk("serial_word", part, q.pop_front());
                    pbits = 0;
                end
            end else begin
                chk("idle_ser_out", ser_out, 0);
                chk("partial_word_gap", pbits, 0);
            end
            prev_exp = exp_op;
            if (exp_op) exp_pulses++;
            if (ser_valid) begin
                run++;
                last4 = {last4[2:0], ser_out};
                pending = (run >= 4) && (last4 == PAT);
            end else begin
                run = 0;
                pending = 1'b0;
            end
            if (pending && mcnt < 65535) mcnt++;
        end
        if (rst) begin
            started = 1'b1;
            q.delete();
            pbits = 0;
            run = 0;
            pending = 1'b0;
            mcnt = 0;
            prev_exp = 1'b0;
        end else if (started && in_valid && in_ready) begin
            q.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (busy && w < 300);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_queue_empty"}, q.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  b6;
        logic [15:0] s2;
        logic [7:0]  w3 [6];
        int          acc [6];
        int          exp_acc [6];
        int          n;
        int          c;
        int          p0;
        int          sent;
        logic        sv_e;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ser_out", ser_out, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_exp_op", exp_op, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_busy", busy, 0);

        // Single word 8'hB6: bits at t+2..t+9, overlapping matches at t+6 and t+9
        b6 = 8'hB6;
        step();
        in_data = b6;
        in_valid = 1'b1;
        @(negedge clk);
        chk("b6_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            sv_e = (k >= 2 && k <= 9);
            chk("b6_ser_valid", ser_valid, sv_e);
            if (sv_e) chk("b6_ser_out", ser_out, b6[9-k]);
            chk("b6_exp_op", exp_op, (k == 6 || k == 9));
            if (k == 1) chk("b6_busy_start", busy, 1);
            if (k == 10) begin
                chk("b6_busy_end", busy, 0);
                chk("b6_match_cnt", match_cnt, 2);
            end
        end

        // Back-to-back 8'h0B, 8'hB0: 16 contiguous bits, matches at u+10 and u+14
        do_reset();
        s2 = 16'h0BB0;
        in_data = 8'h0B;
        in_valid = 1'b1;
        step();
        in_data = 8'hB0;
        step();
        in_valid = 1'b0;
        for (int k = 2; k <= 18; k++) begin
            @(negedge clk);
            sv_e = (k <= 17);
            chk("b2b_ser_valid", ser_valid, sv_e);
            if (sv_e) chk("b2b_ser_out", ser_out, s2[17-k]);
            chk("b2b_exp_op", exp_op, (k == 10 || k == 14));
        end
        chk("b2b_match_cnt", match_cnt, 2);

        // Fill with in_valid held: five consecutive accepts, sixth after first word finishes
        do_reset();
        w3[0] = 8'h11; w3[1] = 8'h2E; w3[2] = 8'h3C;
        w3[3] = 8'h4D; w3[4] = 8'h5A; w3[5] = 8'h69;
        exp_acc[0] = 0; exp_acc[1] = 1; exp_acc[2] = 2;
        exp_acc[3] = 3; exp_acc[4] = 4; exp_acc[5] = 10;
        n = 0;
        c = 0;
        in_valid = 1'b1;
        in_data = w3[0];
        while (n < 6 && c < 60) begin
            @(negedge clk);
            if (in_ready) begin
                acc[n] = c;
                n++;
            end
            step();
            c++;
            in_valid = (n < 6);
            if (n < 6) in_data = w3[n];
        end
        in_valid = 1'b0;
        chk("fill_accepted", n, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < n) chk("fill_accept_cycle", acc[i], exp_acc[i]);
        end
        drain("fill_drain");

        // 8'h01, idle gap, 8'h60: the 1|011 spanning the gap must not match
        do_reset();
        p0 = exp_pulses;
        in_data = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain("gap_first");
        step();
        in_data = 8'h60;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain("gap_second");
        chk("gap_match_cnt", match_cnt, 0);
        chk("gap_exp_pulses", exp_pulses - p0, 0);

        // Reset mid-word with three words queued
        do_reset();
        in_data = 8'hBB;
        in_valid = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_pre_ser_valid", ser_valid, 1);
        chk("mid_pre_match_cnt", match_cnt, 1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ser_valid", ser_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_match_cnt", match_cnt, 0);
        repeat (20) begin
            @(negedge clk);
            chk("mid_no_bits", ser_valid, 0);
        end

        // Random traffic with periodic idle windows
        do_reset();
        sent = 0;
        c = 0;
        while (sent < 2000 && c < 40000) begin
            in_valid = ($urandom_range(0, 7) != 0) && ((c % 500) < 470);
            in_data = 8'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            step();
            c++;
        end
        in_valid = 1'b0;
        chk("random_sent", sent, 2000);
        drain("random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
